shift_sequencer: RTL and testbench

//   Multi-cycle shift unit: executes SLL/SRL/(SRA)/LUI by shifting at most STEP bits per clock

---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_sequencer_if.sv | 24 ++
 rtl/shift_sequencer_shift_step.sv | 23 ++
 rtl/shift_sequencer.sv | 116 +++++++++++
 tb/tb_shift_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared states and constants for the multi-cycle shift unit
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LUI_SHAMT       = 5'd16;
    localparam logic       SHAMT_SRC_VAR   = 1'b0;
    localparam logic       SHAMT_SRC_CONST = 1'b1;
    localparam int         STEP_DEFAULT    = 4;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle between the EX stage and the shift unit
interface shift_sequencer_if;
    logic        start;
    logic        flush;
    logic [2:0]  control;
    logic        lui;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  constant_shift;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, flush, control, lui, a, b, constant_shift,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, flush, control, lui, a, b, constant_shift,
        output ready, busy, done, result
    );
endinterface

// File: rtl/shift_sequencer_shift_step.sv
// rtl/shift_sequencer_shift_step.sv - one partial shift of the accumulator by at most STEP bits
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int STEP = STEP_DEFAULT,
    parameter int SW   = $clog2(STEP + 1)
) (
    input  logic [31:0]   i_acc,
    input  logic [SW-1:0] i_s,
    input  logic          i_dir,
    input  logic          i_arith,
    output logic [31:0]   o_res
);

    always_comb begin
        o_res = i_acc >> i_s;
        if (i_dir)
            o_res = i_acc << i_s;
        else if (i_arith)
            o_res = $signed(i_acc) >>> i_s;
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - SLL/SRL/SRA/LUI in STEP-bit slices; SHIFT_SEQ_SRA_EN enables arithmetic right shifts
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int STEP = STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    localparam int SW = $clog2(STEP + 1);

    state_t        r_state, w_next;
    logic [31:0]   r_acc, w_acc_next, r_result, w_step_res;
    logic [4:0]    r_cnt, w_cnt_next, w_amount;
    logic          r_dir, w_dir_next, r_arith, w_arith_next;
    logic          w_req_dir, w_req_arith, w_enter_done;
    logic [SW-1:0] w_s;
    logic          w_unused;

    assign w_unused = ^{bus.a[31:5], bus.control[0]};

    always_comb begin
        w_amount    = bus.a[4:0];
        w_req_dir   = bus.control[1];
        w_req_arith = 1'b0;
        if (bus.lui) begin
            w_amount  = LUI_SHAMT;
            w_req_dir = 1'b1;
        end else begin
            if (bus.control[2] == SHAMT_SRC_CONST)
                w_amount = bus.constant_shift;
`ifdef SHIFT_SEQ_SRA_EN
            w_req_arith = bus.control[0] & ~bus.control[1];
`else
            w_req_arith = 1'b0;
`endif
        end
    end

    // Last slice may be shorter than STEP, so cnt lands exactly on zero.
    assign w_s = (r_cnt >= 5'(STEP)) ? SW'(STEP) : SW'(r_cnt);

    shift_step #(.STEP(STEP), .SW(SW)) u_step (
        .i_acc   (r_acc),
        .i_s     (w_s),
        .i_dir   (r_dir),
        .i_arith (r_arith),
        .o_res   (w_step_res)
    );

    always_comb begin
        w_next       = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_arith_next = r_arith;
        w_enter_done = 1'b0;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    w_next = IDLE;
                    if (bus.start) begin
                        w_acc_next   = bus.b;
                        w_cnt_next   = w_amount;
                        w_dir_next   = w_req_dir;
                        w_arith_next = w_req_arith;
                        if (w_amount == 5'd0) begin
                            w_next       = DONE;
                            w_enter_done = 1'b1;
                        end else begin
                            w_next = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    w_acc_next = w_step_res;
                    w_cnt_next = r_cnt - 5'(w_s);
                    if (w_cnt_next == 5'd0) begin
                        w_next       = DONE;
                        w_enter_done = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
            r_dir    <= 1'b0;
            r_arith  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
            r_arith <= w_arith_next;
            if (w_enter_done)
                r_result <= w_acc_next;
        end
    end

    assign bus.ready  = (r_state == IDLE) || (r_state == DONE);
    assign bus.busy   = (r_state == SHIFT);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and randomized checks of shift_sequencer against a cycle-count model
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int STEP = 4;
`ifdef SHIFT_SEQ_SRA_EN
    localparam logic [31:0] SRA_EXP = 32'hF800_0000;
`else
    localparam logic [31:0] SRA_EXP = 32'h0800_0000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    shift_sequencer_if bus();

    shift_sequencer #(.STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    bit          m_pending = 1'b0;
    bit          m_ready;
    int          m_done_at = 0;
    int          m_amt;
    logic [31:0] m_exp    = 32'd0;
    logic [31:0] m_result = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic int f_amount(input logic lui, input logic [2:0] ctrl,
                                    input logic [31:0] a, input logic [4:0] cs);
        if (lui) return 16;
        if (ctrl[2]) return int'(cs);
        return int'(a[4:0]);
    endfunction

    function automatic logic [31:0] f_result(input logic lui, input logic [2:0] ctrl,
                                             input logic [31:0] b, input int amt);
        if (lui) return b << 16;
        if (ctrl[1]) return b << amt;
`ifdef SHIFT_SEQ_SRA_EN
        if (ctrl[0]) return 32'($signed(b) >>> amt);
`endif
        return b >> amt;
    endfunction

    // Model: an accepted op finishes 1+ceil(amount/STEP) cycles later; result updates then.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pending = 1'b0;
            m_result  = 32'd0;
        end else begin
            m_ready = !(m_pending && cyc < m_done_at);
            if (bus.flush) begin
                m_pending = 1'b0;
            end else if (m_ready && bus.start) begin
                m_amt     = f_amount(bus.lui, bus.control, bus.a, bus.constant_shift);
                m_pending = 1'b1;
                m_done_at = cyc + 1 + (m_amt + STEP - 1) / STEP;
                m_exp     = f_result(bus.lui, bus.control, bus.b, m_amt);
            end else if (m_pending && cyc == m_done_at) begin
                m_pending = 1'b0;
            end
            cyc++;
            if (m_pending && cyc == m_done_at)
                m_result = m_exp;
        end
    end

    always @(negedge clk) begin
        check("ready",  32'(bus.ready), 32'(!(m_pending && cyc < m_done_at)));
        check("busy",   32'(bus.busy),  32'(m_pending && cyc < m_done_at));
        check("done",   32'(bus.done),  32'(m_pending && cyc == m_done_at));
        check("result", bus.result, m_result);
    end

    task automatic do_op(input logic lui, input logic [2:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] cs,
                         input int exp_lat, input logic [31:0] exp_res, input string name);
        int  c0;
        bit  got;
        @(posedge clk); #1;
        bus.lui = lui; bus.control = ctrl; bus.a = a; bus.b = b;
        bus.constant_shift = cs; bus.start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        check({name, " latency"}, 32'(cyc - c0), 32'(exp_lat));
        check({name, " result"}, bus.result, exp_res);
    endtask

    int          c0;
    int          n_done;
    int          d_cyc[2];
    logic [31:0] d_res[2];

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.control = 3'b000; bus.lui = 1'b0;
        bus.a = 32'd0; bus.b = 32'd0; bus.constant_shift = 5'd0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        check("reset ready",  32'(bus.ready), 32'd1);
        check("reset busy",   32'(bus.busy),  32'd0);
        check("reset done",   32'(bus.done),  32'd0);
        check("reset result", bus.result, 32'd0);

        do_op(1'b0, 3'b110, 32'd0, 32'h0000_0001, 5'd31, 9, 32'h8000_0000, "sll31");
        do_op(1'b0, 3'b000, 32'd0, 32'hDEAD_BEEF, 5'd7, 1, 32'hDEAD_BEEF, "zero");
        do_op(1'b1, 3'b001, 32'h1F, 32'h0000_1234, 5'd3, 5, 32'h1234_0000, "lui");
        do_op(1'b0, 3'b101, 32'd0, 32'h8000_0000, 5'd4, 2, SRA_EXP, "sra");

        // Back-to-back: start held from op1 through its DONE cycle, operands switch to op2 meanwhile.
        @(posedge clk); #1;
        bus.lui = 1'b0; bus.control = 3'b010; bus.a = 32'd8; bus.b = 32'd3; bus.start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        bus.control = 3'b000; bus.a = 32'd4; bus.b = 32'h0000_00F0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (n_done < 2) begin
                    d_cyc[n_done] = cyc - c0;
                    d_res[n_done] = bus.result;
                end
                n_done++;
            end
            @(posedge clk); #1;
            if (cyc == c0 + 4) bus.start = 1'b0;
        end
        check("b2b done count", 32'(n_done), 32'd2);
        if (n_done == 2) begin
            check("b2b op1 latency", 32'(d_cyc[0]), 32'd3);
            check("b2b op1 result",  d_res[0], 32'h0000_0300);
            check("b2b op2 latency", 32'(d_cyc[1]), 32'd5);
            check("b2b op2 result",  d_res[1], 32'h0000_000F);
        end

        // Flush in the third cycle of a 31-bit shift.
        bus.control = 3'b110; bus.constant_shift = 5'd31; bus.b = 32'd1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy",   32'(bus.busy),  32'd0);
        check("flush ready",  32'(bus.ready), 32'd1);
        check("flush result", bus.result, 32'h0000_000F);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("flush no done", 32'(n_done), 32'd0);

        // Asynchronous reset in the middle of a shift.
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #2; reset = 1'b1;
        #1;
        check("areset ready",  32'(bus.ready), 32'd1);
        check("areset busy",   32'(bus.busy),  32'd0);
        check("areset done",   32'(bus.done),  32'd0);
        check("areset result", bus.result, 32'd0);
        @(posedge clk); #2; reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            bus.start          = 1'($urandom_range(0, 1));
            bus.flush          = ($urandom_range(0, 19) == 0);
            bus.lui            = ($urandom_range(0, 7) == 0);
            bus.control        = 3'($urandom);
            bus.a              = $urandom;
            bus.b              = $urandom;
            bus.constant_shift = 5'($urandom);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
